// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the pipeline hazard sequencer.
package pipeline_pkg;

    // PC-source mux encodings; 2'b11 is never driven.
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Register $zero can never carry a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Sequencer state: normal flow, or frozen behind a slow data-memory access.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazardState_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Enable-driven event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, holding once the maximum value is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, MEM-stage
// redirects and data-memory freezes with a bounded wait, plus statistics.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15,   // at least 1
    parameter int WAIT_W   = 4     // 2**WAIT_W must exceed MAX_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       idex_rt,
    input  logic             idex_mem_read,
    input  logic             exmem_zero,
    input  logic             exmem_branch_eq,
    input  logic             exmem_branch_ne,
    input  logic             exmem_jump,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    hazardState_t      stateReg, stateNext;
    logic [WAIT_W-1:0] waitCntReg, waitCntNext;
    logic              forceReleaseReg, forceReleaseNext;
    logic              memTimeoutReg, memTimeoutNext;

    logic memBusyRaw, memBusy, taken, redirect, loadUse;
    logic redirectTaken;

    logic [1:0]       cntEn;
    logic [CNT_W-1:0] cntVal [2];

    // Hazard detection terms; a forced release masks the busy condition for one cycle.
    always_comb begin
        memBusyRaw = (exmem_mem_read | exmem_mem_write) & ~dmem_ready;
        memBusy    = memBusyRaw & ~forceReleaseReg;
        taken      = (exmem_branch_eq & exmem_zero) | (exmem_branch_ne & ~exmem_zero);
        redirect   = taken | exmem_jump;
        loadUse    = idex_mem_read && (idex_rt != REG_ZERO) &&
                     ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    end

    // Next-state logic: track consecutive busy cycles and arm the forced release.
    always_comb begin
        stateNext        = stateReg;
        waitCntNext      = waitCntReg;
        forceReleaseNext = 1'b0;
        memTimeoutNext   = memTimeoutReg | forceReleaseReg;
        case (stateReg)
            RUN: begin
                waitCntNext = '0;
                if (memBusy) begin
                    stateNext        = MEM_WAIT;
                    waitCntNext      = WAIT_W'(1);
                    forceReleaseNext = (MAX_WAIT == 1);
                end
            end
            MEM_WAIT: begin
                if (memBusy) begin
                    waitCntNext      = waitCntReg + 1'b1;
                    forceReleaseNext = (waitCntReg == WAIT_W'(MAX_WAIT - 1));
                end else begin
                    // Ready (or forced release): this cycle already follows RUN rules.
                    stateNext   = RUN;
                    waitCntNext = '0;
                end
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    // Mealy pipeline controls, highest-priority hazard first.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        pc_src        = PCSRC_SEQ;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        pipe_hold     = 1'b0;
        redirectTaken = 1'b0;
        if (!reset) begin
            if (memBusy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
            end else if (redirect) begin
                // The ID instruction gets flushed, so any load-use there is moot.
                redirectTaken = 1'b1;
                pc_src        = exmem_jump ? PCSRC_JUMP : PCSRC_BRANCH;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                exmem_flush   = 1'b1;
            end else if (loadUse) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    // State, wait counter and sticky timeout register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg        <= RUN;
            waitCntReg      <= '0;
            forceReleaseReg <= 1'b0;
            memTimeoutReg   <= 1'b0;
        end else begin
            stateReg        <= stateNext;
            waitCntReg      <= waitCntNext;
            forceReleaseReg <= forceReleaseNext;
            memTimeoutReg   <= memTimeoutNext;
        end
    end

    assign mem_timeout = memTimeoutReg;

    // Statistics: index 0 counts stalled-PC cycles, index 1 counts redirects.
    assign cntEn[0] = ~pc_write;
    assign cntEn[1] = redirectTaken;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_stat
            hazard_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .en    (cntEn[gi]),
                .count (cntVal[gi])
            );
        end
    endgenerate

    assign stall_cycles = cntVal[0];
    assign flush_events = cntVal[1];

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 16;

    // Expected control vectors: {pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush, pipe_hold}
    localparam logic [7:0] CTL_NORMAL = 8'b1100_0000;
    localparam logic [7:0] CTL_LDUSE  = 8'b0000_0100;
    localparam logic [7:0] CTL_BRANCH = 8'b1101_1110;
    localparam logic [7:0] CTL_JUMP   = 8'b1110_1110;
    localparam logic [7:0] CTL_HOLD   = 8'b0000_0001;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, idex_rt;
    logic             id_uses_rt, idex_mem_read;
    logic             exmem_zero, exmem_branch_eq, exmem_branch_ne, exmem_jump;
    logic             exmem_mem_read, exmem_mem_write, dmem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic             pipe_hold, mem_timeout;
    logic [1:0]       pc_src;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (15),
        .WAIT_W   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .idex_rt         (idex_rt),
        .idex_mem_read   (idex_mem_read),
        .exmem_zero      (exmem_zero),
        .exmem_branch_eq (exmem_branch_eq),
        .exmem_branch_ne (exmem_branch_ne),
        .exmem_jump      (exmem_jump),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .pipe_hold       (pipe_hold),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [7:0] exp);
        checkEq(tag, {24'd0, pc_write, ifid_write, pc_src, ifid_flush, idex_flush,
                      exmem_flush, pipe_hold}, {24'd0, exp});
    endtask

    task automatic setIdle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        idex_rt = 5'd0; idex_mem_read = 1'b0;
        exmem_zero = 1'b0; exmem_branch_eq = 1'b0; exmem_branch_ne = 1'b0;
        exmem_jump = 1'b0; exmem_mem_read = 1'b0; exmem_mem_write = 1'b0;
        dmem_ready = 1'b1;
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle mid-cycle before sampling.
    task automatic settle();
        #3;
    endtask

    initial begin
        reset = 1'b1;
        setIdle();
        nextCycle();
        nextCycle();
        reset = 1'b0;
        settle();
        checkCtl("reset_ctl", CTL_NORMAL);
        checkEq("reset_stall", 32'(stall_cycles), 32'd0);
        checkEq("reset_flush", 32'(flush_events), 32'd0);
        checkEq("reset_timeout", 32'(mem_timeout), 32'd0);

        // Load-use on rs: one bubble.
        nextCycle();
        idex_rt = 5'd8; idex_mem_read = 1'b1; id_rs = 5'd8;
        settle();
        checkCtl("lduse_rs", CTL_LDUSE);
        nextCycle();
        setIdle();
        settle();
        checkCtl("lduse_after", CTL_NORMAL);
        checkEq("lduse_stall", 32'(stall_cycles), 32'd1);

        // Load into $zero never stalls.
        nextCycle();
        idex_rt = 5'd0; idex_mem_read = 1'b1; id_rs = 5'd0;
        settle();
        checkCtl("lduse_zero", CTL_NORMAL);

        // rt matches but the instruction does not read rt.
        nextCycle();
        idex_rt = 5'd9; idex_mem_read = 1'b1; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        settle();
        checkCtl("lduse_rt_unused", CTL_NORMAL);
        nextCycle();
        id_uses_rt = 1'b1;
        settle();
        checkCtl("lduse_rt_used", CTL_LDUSE);

        // beq taken: redirect to branch target with all flushes.
        nextCycle();
        setIdle();
        exmem_branch_eq = 1'b1; exmem_zero = 1'b1;
        settle();
        checkCtl("beq_taken", CTL_BRANCH);
        nextCycle();
        setIdle();
        exmem_branch_ne = 1'b1; exmem_zero = 1'b1;
        settle();
        checkCtl("bne_not_taken", CTL_NORMAL);
        checkEq("beq_flush_cnt", 32'(flush_events), 32'd1);
        checkEq("lduse_stall2", 32'(stall_cycles), 32'd2);

        // Memory wait of three cycles, then release on ready.
        nextCycle();
        setIdle();
        exmem_mem_read = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checkCtl($sformatf("memwait_hold%0d", i), CTL_HOLD);
            nextCycle();
        end
        dmem_ready = 1'b1;
        settle();
        checkCtl("memwait_ready", CTL_NORMAL);
        nextCycle();
        setIdle();
        settle();
        checkEq("memwait_stall", 32'(stall_cycles), 32'd5);
        checkEq("memwait_timeout", 32'(mem_timeout), 32'd0);

        // Jump together with load-use: redirect wins, no stall.
        nextCycle();
        exmem_jump = 1'b1; idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
        settle();
        checkCtl("jump_lduse", CTL_JUMP);

        // Memory never ready: forced release after 15 hold cycles.
        nextCycle();
        setIdle();
        exmem_mem_write = 1'b1; dmem_ready = 1'b0;
        settle();
        checkEq("jump_flush_cnt", 32'(flush_events), 32'd2);
        checkEq("jump_stall_cnt", 32'(stall_cycles), 32'd5);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) settle();
            checkCtl($sformatf("timeout_hold%0d", i), CTL_HOLD);
            nextCycle();
        end
        settle();
        checkCtl("timeout_release", CTL_NORMAL);
        nextCycle();
        settle();
        checkCtl("timeout_rehold", CTL_HOLD);
        checkEq("timeout_flag", 32'(mem_timeout), 32'd1);
        checkEq("timeout_stall", 32'(stall_cycles), 32'd20);
        nextCycle();
        setIdle();
        settle();
        checkEq("timeout_sticky", 32'(mem_timeout), 32'd1);
        checkEq("timeout_stall2", 32'(stall_cycles), 32'd21);

        // Reset in the middle of a memory wait.
        nextCycle();
        exmem_mem_read = 1'b1; dmem_ready = 1'b0;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        setIdle();
        settle();
        checkCtl("midwait_reset_ctl", CTL_NORMAL);
        checkEq("midwait_reset_stall", 32'(stall_cycles), 32'd0);
        checkEq("midwait_reset_flush", 32'(flush_events), 32'd0);
        checkEq("midwait_reset_timeout", 32'(mem_timeout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central hazard sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC-source select.
- Resolves three hazard types: load-use (one-bubble stall), taken branch or jump resolved in MEM (three-stage flush and redirect), and data-memory wait states (whole-pipeline freeze, bounded by a timeout).
- Sits beside the pipeline registers and keeps saturating stall and flush statistics.

Parameters:
- CNT_W, 16: width of statistics counters.
- MAX_WAIT, 15: maximum consecutive memory wait cycles before forced release; must be at least 1.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1: pipeline clock. All state changes on the rising edge.
- reset  in  1: synchronous, active-high.
- id_rs  in  5: rs of the instruction in ID.
- id_rt  in  5: rt of the instruction in ID.
- id_uses_rt  in  1: the ID instruction reads rt as a source.
- idex_rt  in  5: destination rt of the instruction in EX.
- idex_mem_read  in  1: the EX instruction is a load.
- exmem_zero  in  1: Zero flag held in EX/MEM.
- exmem_branch_eq  in  1: BranchEquals control held in EX/MEM.
- exmem_branch_ne  in  1: BranchNotEquals control held in EX/MEM.
- exmem_jump  in  1: Jump control held in EX/MEM.
- exmem_mem_read  in  1: MemRead control held in EX/MEM.
- exmem_mem_write  in  1: MemWrite control held in EX/MEM.
- dmem_ready  in  1: data memory completes the access this cycle.
- pc_write  out  1: PC load enable.
- pc_src  out  2: 00 = PC+4, 01 = branch target, 10 = jump target. 11 is never driven.
- ifid_write  out  1: IF/ID load enable.
- ifid_flush  out  1: IF/ID load with a bubble.
- idex_flush  out  1: ID/EX load with a bubble.
- exmem_flush  out  1: EX/MEM load with a bubble.
- pipe_hold  out  1: freezes ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1: sticky; set when a memory wait was force-released.
- stall_cycles  out  CNT_W: count of cycles with pc_write=0.
- flush_events  out  CNT_W: count of redirects.

Behaviour:
- Clock and reset: reset is synchronous and active-high. Clock and reset ports are clk and reset.
- FSM states: RUN, MEM_WAIT. Outputs are Mealy, combinational from state and inputs. Counters and the sticky flag are registered.
- Reset effect: state becomes RUN; wait_cnt, stall_cycles, flush_events and mem_timeout become 0.
- Outputs on the first cycle after reset follow the RUN rules. With idle inputs this gives pc_write=1, ifid_write=1, pc_src=00 and all flushes/hold at 0.
- Derived signals:
  - mem_busy = (exmem_mem_read | exmem_mem_write) & ~dmem_ready.
  - taken = exmem_branch_eq & exmem_zero | exmem_branch_ne & ~exmem_zero.
  - redirect = taken | exmem_jump.
  - load_use = idex_mem_read & (idex_rt != 0) & (idex_rt == id_rs | id_uses_rt & idex_rt == id_rt).
- Priority, evaluated every cycle (highest first): reset > mem_busy > redirect > load_use > normal.
- mem_busy:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1. No flushes; pc_src=00.
  - Transition: RUN goes to MEM_WAIT.
  - In MEM_WAIT, wait_cnt increments each busy cycle.
  - When dmem_ready rises, the same cycle evaluates as RUN: lower-priority rules apply, state returns to RUN and wait_cnt clears.
- Timeout:
  - In MEM_WAIT with wait_cnt == MAX_WAIT-1 and still busy, the next cycle is force-released.
  - Force release means mem_busy is ignored for one cycle, mem_timeout is set, and state returns to RUN.
- redirect:
  - Outputs: pc_src = 10 if exmem_jump, else 01. Jump wins if both are set.
  - pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - flush_events increments once per redirect cycle.
  - A redirect overrides a simultaneous load_use: no stall is applied, because the ID instruction is flushed.
- load_use:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - Exactly one bubble results, because the load advances to MEM the next cycle.
- stall_cycles: increments in every cycle where pc_write=0.
- Both counters saturate at all-ones and never wrap.
- Reset asserted mid-wait or mid-stall: the next cycle is RUN with counters at zero. Any in-flight hold is dropped.

Decomposition:
- Shared package pipeline_pkg holds:
  - the pc_src encodings PCSRC_SEQ, PCSRC_BRANCH, PCSRC_JUMP;
  - the FSM state enum;
  - REG_ZERO = 5'd0.
- Natural sub-module: hazard_sat_counter (parameterised CNT_W, enable input, saturating). Instantiate it twice.

Test Plan:
- Load-use: lw $t0 in EX (idex_rt=8, idex_mem_read=1), ID uses rs=8 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1.
- Same load but idex_rt=0, or rt match with id_uses_rt=0 -> no stall.
- beq taken (branch_eq=1, zero=1) -> one cycle of pc_src=01 with all three flushes; flush_events=1. bne with zero=1 -> no redirect.
- Load from memory with dmem_ready low for 3 cycles -> pipe_hold=1 for 3 cycles, then release on the ready cycle; stall_cycles=3; mem_timeout stays 0.
- dmem_ready held low with MAX_WAIT=15 -> forced release after 15 hold cycles; mem_timeout=1 until reset.
- Jump plus load_use in the same cycle -> pc_src=10 with flushes and no stall. Reset asserted during MEM_WAIT -> next cycle shows RUN outputs with all counters at 0.
